// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds the IF-stage BTB prediction for one branch and checks it against the ID outcome.
// Optional hit/mispredict statistics counters are enabled with `define BRANCH_STAT_EN.
module branch_resolve_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int PREDICT_SIZE = 2,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    IF_branch,
   input  logic                    IF_hit,
   input  logic [PREDICT_SIZE-1:0] IF_taken,
   input  logic [DATA_WIDTH-1:0]   IF_pc,
   input  logic [DATA_WIDTH-1:0]   IF_target,
   input  logic                    ID_resolved,
   input  logic                    ID_taken,
   input  logic [DATA_WIDTH-1:0]   ID_target,
   output logic                    ID_branch,
   output logic [DATA_WIDTH-1:0]   ID_branch_pc,
   output logic                    misprediction,
   output logic                    redirect_valid,
   output logic [DATA_WIDTH-1:0]   redirect_pc,
   output logic                    flush
`ifdef BRANCH_STAT_EN
   ,
   output logic [31:0]             stat_branches,
   output logic [31:0]             stat_mispredicts
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_FLUSH
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
   localparam logic [PREDICT_SIZE-1:0] TAKEN_MIN = {1'b1, {(PREDICT_SIZE-1){1'b0}}};

   state_t                  state, next_state;
   logic [3:0]              flush_cnt, next_flush_cnt;
   logic                    rec_valid;
   logic [DATA_WIDTH-1:0]   rec_pc;
   logic                    rec_pred_taken;
   logic [DATA_WIDTH-1:0]   rec_target;
   logic                    capture;
   logic                    if_pred_taken;
   logic [DATA_WIDTH-1:0]   fall_through;

   // A BTB miss is treated as weakly taken.
   assign if_pred_taken = ~IF_hit | (IF_taken >= TAKEN_MIN);
   assign fall_through  = rec_pc + DATA_WIDTH'(4);

   assign ID_branch     = rec_valid & ID_resolved;
   assign ID_branch_pc  = rec_pc;
   assign misprediction = ID_branch &
                          ((rec_pred_taken != ID_taken) | (ID_taken & (rec_target != ID_target)));
   assign capture       = en & IF_branch & (state != S_FLUSH) & ~misprediction;
   assign flush         = (state == S_FLUSH);

   always_comb begin
      next_state     = state;
      next_flush_cnt = flush_cnt;
      case (state)
         S_IDLE: begin
            if (capture)
               next_state = S_ARMED;
         end
         S_ARMED: begin
            if (en) begin
               if (misprediction) begin
                  next_state     = S_FLUSH;
                  next_flush_cnt = FLUSH_LOAD;
               end else if (ID_branch && !capture) begin
                  next_state = S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            if (en) begin
               if (flush_cnt <= 4'd1) begin
                  next_state     = S_IDLE;
                  next_flush_cnt = 4'd0;
               end else begin
                  next_flush_cnt = flush_cnt - 4'd1;
               end
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         flush_cnt <= 4'd0;
      end else begin
         state     <= next_state;
         flush_cnt <= next_flush_cnt;
      end
   end

   // A resolve on the same edge uses the old record before the new one loads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rec_valid      <= 1'b0;
         rec_pc         <= '0;
         rec_pred_taken <= 1'b0;
         rec_target     <= '0;
      end else if (en) begin
         if (capture) begin
            rec_valid      <= 1'b1;
            rec_pc         <= IF_pc;
            rec_pred_taken <= if_pred_taken;
            rec_target     <= IF_target;
         end else if (ID_branch) begin
            rec_valid <= 1'b0;
         end
      end
   end

   // redirect_valid is a single-cycle pulse even if the pipeline stalls right after.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= en & misprediction;
         if (en && misprediction)
            redirect_pc <= ID_taken ? ID_target : fall_through;
      end
   end

`ifdef BRANCH_STAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (en && ID_branch) begin
         if (stat_branches != 32'hFFFF_FFFF)
            stat_branches <= stat_branches + 32'd1;
         if (misprediction && (stat_mispredicts != 32'hFFFF_FFFF))
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed test-plan scenarios plus random traffic vs. a behavioural model.
// Define BRANCH_STAT_EN to also check the statistics counters.
module tb_branch_resolve_unit;

   localparam int DW = 32;
   localparam int FC = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          IF_branch = 1'b0;
   logic          IF_hit = 1'b0;
   logic [1:0]    IF_taken = '0;
   logic [DW-1:0] IF_pc = '0;
   logic [DW-1:0] IF_target = '0;
   logic          ID_resolved = 1'b0;
   logic          ID_taken = 1'b0;
   logic [DW-1:0] ID_target = '0;
   logic          ID_branch;
   logic [DW-1:0] ID_branch_pc;
   logic          misprediction;
   logic          redirect_valid;
   logic [DW-1:0] redirect_pc;
   logic          flush;
`ifdef BRANCH_STAT_EN
   logic [31:0]   stat_branches;
   logic [31:0]   stat_mispredicts;
`endif

   branch_resolve_unit #(.DATA_WIDTH(DW), .PREDICT_SIZE(2), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .en(en),
      .IF_branch(IF_branch), .IF_hit(IF_hit), .IF_taken(IF_taken),
      .IF_pc(IF_pc), .IF_target(IF_target),
      .ID_resolved(ID_resolved), .ID_taken(ID_taken), .ID_target(ID_target),
      .ID_branch(ID_branch), .ID_branch_pc(ID_branch_pc), .misprediction(misprediction),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
`ifdef BRANCH_STAT_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Behavioural model: one pending prediction and a count of remaining flush cycles.
   bit          m_valid;
   logic [31:0] m_pc, m_target;
   bit          m_pred;
   int          m_flush_left;
   bit          m_rv;
   logic [31:0] m_rpc;
   longint      m_br, m_mp;

   logic        last_idb, last_mis, last_rv, last_flush;
   logic [31:0] last_rpc;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_valid = 0; m_pc = 0; m_target = 0; m_pred = 0;
      m_flush_left = 0; m_rv = 0; m_rpc = 0; m_br = 0; m_mp = 0;
   endtask

   task automatic applyStimulus(input logic e, input logic ib, input logic ih, input logic [1:0] it,
                                input logic [31:0] ipc, input logic [31:0] itg,
                                input logic r, input logic idt, input logic [31:0] idtg);
      bit exp_idb, exp_mis;
      @(negedge clk);
      en = e; IF_branch = ib; IF_hit = ih; IF_taken = it; IF_pc = ipc; IF_target = itg;
      ID_resolved = r; ID_taken = idt; ID_target = idtg;
      #1;
      exp_idb = m_valid && r;
      exp_mis = exp_idb && ((m_pred != idt) || (idt && (m_target != idtg)));
      checkOutput("ID_branch", 32'(ID_branch), 32'(exp_idb));
      checkOutput("misprediction", 32'(misprediction), 32'(exp_mis));
      if (m_valid)
         checkOutput("ID_branch_pc", ID_branch_pc, m_pc);
      checkOutput("flush", 32'(flush), 32'(m_flush_left > 0));
      checkOutput("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      checkOutput("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_STAT_EN
      checkOutput("stat_branches", stat_branches, 32'(m_br));
      checkOutput("stat_mispredicts", stat_mispredicts, 32'(m_mp));
`endif
      last_idb = ID_branch; last_mis = misprediction; last_rv = redirect_valid;
      last_flush = flush; last_rpc = redirect_pc;
      @(posedge clk);
      m_rv = e && exp_mis;
      if (e) begin
         if (exp_idb) begin
            m_br++;
            if (exp_mis) m_mp++;
         end
         if (m_flush_left > 0) begin
            m_flush_left--;
         end else if (exp_mis) begin
            m_rpc = idt ? idtg : m_pc + 32'd4;
            m_flush_left = FC;
            m_valid = 0;
         end else if (ib) begin
            m_valid = 1; m_pc = ipc; m_target = itg;
            m_pred = ih ? it[1] : 1'b1;
         end else if (exp_idb) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
   endtask

   int flush_count;

   initial begin
      modelReset();
      #12;
      checkOutput("reset_flush", 32'(flush), 32'd0);
      checkOutput("reset_redirect_valid", 32'(redirect_valid), 32'd0);
      checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
      rst = 1'b1;
      idle(2);

      // Correctly predicted taken branch
      applyStimulus(1, 1, 1, 2'b11, 32'h100, 32'h200, 0, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 1, 32'h200);
      checkOutput("tp_ok_branch", 32'(last_idb), 32'd1);
      checkOutput("tp_ok_mis", 32'(last_mis), 32'd0);
      idle(2);
      checkOutput("tp_ok_noflush", 32'(last_flush), 32'd0);

      // Predicted taken, actually not taken
      applyStimulus(1, 1, 1, 2'b10, 32'h100, 32'h200, 0, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 0, 32'h0);
      checkOutput("tp_nt_mis", 32'(last_mis), 32'd1);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      checkOutput("tp_nt_rv", 32'(last_rv), 32'd1);
      checkOutput("tp_nt_rpc", last_rpc, 32'h104);
      checkOutput("tp_nt_flush", 32'(last_flush), 32'd1);
      idle(FC + 1);
      checkOutput("tp_nt_idle", 32'(last_flush), 32'd0);

      // Target mismatch; IF branch in the same cycle must be dropped
      applyStimulus(1, 1, 1, 2'b11, 32'h180, 32'h200, 0, 0, 0);
      applyStimulus(1, 1, 1, 2'b11, 32'h500, 32'h600, 1, 1, 32'h300);
      checkOutput("tp_tgt_mis", 32'(last_mis), 32'd1);
      idle(1);
      checkOutput("tp_tgt_rpc", last_rpc, 32'h300);
      idle(FC);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 1, 32'h600);
      checkOutput("tp_tgt_nocapture", 32'(last_idb), 32'd0);

      // Fall-through wraps at the top of the address space
      applyStimulus(1, 1, 1, 2'b11, 32'hFFFF_FFFC, 32'h40, 0, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 0, 0);
      idle(1);
      checkOutput("tp_wrap_rpc", last_rpc, 32'h0);
      idle(FC);

      // Stall in the middle of a flush stretches it
      applyStimulus(1, 1, 0, 2'b00, 32'h800, 32'h900, 0, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 0, 0);
      flush_count = 0;
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); flush_count += int'(last_flush);
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); flush_count += int'(last_flush);
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); flush_count += int'(last_flush);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
         flush_count += int'(last_flush);
      end
      checkOutput("tp_stall_flush_len", 32'(flush_count), 32'd5);

      // Reset pulse mid-flush
      applyStimulus(1, 1, 1, 2'b11, 32'h900, 32'hA00, 0, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      checkOutput("tp_rst_flush", 32'(flush), 32'd0);
      checkOutput("tp_rst_rv", 32'(redirect_valid), 32'd0);
      modelReset();
      #1 rst = 1'b1;

      // Three resolves, two of them mispredicted
      applyStimulus(1, 1, 1, 2'b11, 32'h100, 32'h200, 0, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 1, 32'h200);
      applyStimulus(1, 1, 1, 2'b01, 32'h110, 32'h200, 0, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 1, 32'h200);
      idle(FC);
      applyStimulus(1, 1, 1, 2'b11, 32'h120, 32'h200, 0, 0, 0);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 1, 0, 0);
      idle(FC + 1);
`ifdef BRANCH_STAT_EN
      checkOutput("tp_stat_br", stat_branches, 32'd3);
      checkOutput("tp_stat_mp", stat_mispredicts, 32'd2);
`endif

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         logic [31:0] pc, tg, itg;
         pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'($urandom_range(0, 63)) * 4;
         tg  = 32'h200 + 32'($urandom_range(0, 3)) * 32'h100;
         itg = 32'h200 + 32'($urandom_range(0, 3)) * 32'h100;
         applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
                       pc, tg, 1'($urandom), 1'($urandom), itg);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the BTB prediction path: captures the IF-stage prediction (hit, 2-bit counter, target) per branch and checks it against the outcome resolved in ID.
- Drives ID_branch, ID_branch_pc and misprediction back to the BTB, plus redirect_pc and flush to the PC/IF logic.
- Sits between the BTB outputs and the ID-stage branch comparator.

Parameters:
DATA_WIDTH, 32, PC and target address width
PREDICT_SIZE, 2, width of the saturating-counter prediction field; MSB=1 means predict taken
FLUSH_CYCLES, 1, cycles flush is held after a misprediction (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
en  input  1  pipeline advance; 0 = stall, all state frozen
IF_branch  input  1  IF instruction is a branch
IF_hit  input  1  BTB hit for IF_pc
IF_taken  input  PREDICT_SIZE  BTB prediction bits
IF_pc  input  DATA_WIDTH  PC of IF instruction
IF_target  input  DATA_WIDTH  BTB predicted target
ID_resolved  input  1  ID stage has resolved the branch held in the record this cycle
ID_taken  input  1  actual direction
ID_target  input  DATA_WIDTH  actual target
ID_branch  output  1  record valid and ID_resolved (BTB update strobe)
ID_branch_pc  output  DATA_WIDTH  captured branch PC
misprediction  output  1  combinational compare result, valid when ID_branch=1
redirect_valid  output  1  one-cycle pulse, load redirect_pc into PC
redirect_pc  output  DATA_WIDTH  correct next PC
flush  output  1  kill IF/ID contents

Behaviour:
- Record registers: rec_valid, rec_pc, rec_pred_taken, rec_target. Reset: all 0.
- Capture: rising edge with en=1, IF_branch=1, state != FLUSH, and no misprediction this cycle -> rec_valid=1, rec_pc=IF_pc, rec_pred_taken = IF_hit ? IF_taken[MSB] : 1 (a miss behaves as WEAKLY_TAKEN), rec_target=IF_target.
- Clear: edge with en=1 and ID_branch=1 and no new capture -> rec_valid=0.
- Combinational outputs:
  - ID_branch = rec_valid & ID_resolved.
  - ID_branch_pc = rec_pc.
  - misprediction = ID_branch & ((rec_pred_taken != ID_taken) | (ID_taken & rec_target != ID_target)).
- Fall-through address = rec_pc + 4, modulo 2^DATA_WIDTH (wraps at all-ones).
- FSM states: IDLE (rec empty), ARMED (rec valid), FLUSH.
  - IDLE -> ARMED on capture.
  - ARMED -> IDLE on resolve without misprediction and no capture.
  - ARMED -> ARMED on resolve plus simultaneous capture, or no resolve.
  - ARMED -> FLUSH on misprediction (en=1): load flush counter = FLUSH_CYCLES, rec_valid=0.
  - FLUSH: decrement counter each en=1 cycle; -> IDLE when the counter reaches 0; IF captures ignored.
- Registered outputs:
  - redirect_valid = 1 for exactly the first cycle after entering FLUSH.
  - redirect_pc = ID_taken ? ID_target : rec_pc+4, latched on the mispredicting edge and held until the next misprediction.
  - flush = 1 while in FLUSH.
  - Latency: misprediction at edge N -> redirect_valid and flush high in cycle N+1.
- Reset values: ID_branch=0, misprediction=0, redirect_valid=0, redirect_pc=0, flush=0, ID_branch_pc=0, state=IDLE.
- en=0: no capture, no state change, counter frozen. Combinational outputs still follow the inputs, but the BTB ignores them because its own en is low.
- ID_resolved with rec_valid=0: ignored, misprediction=0.
- Simultaneous resolve and capture on a correct prediction: the resolve uses the old record, then the new record loads on the same edge.
- Reset asserted mid-FLUSH: immediate return to IDLE, flush and redirect_valid drop asynchronously.

Optional Feature:
- Macro BRANCH_STAT_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each en=1 edge with ID_branch=1.
  - stat_mispredicts increments on each such edge with misprediction=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset low, then high with no stimulus -> all outputs 0, state IDLE.
- Hit, IF_taken=2'b11, IF_pc=0x100, IF_target=0x200; next cycle ID_resolved=1, ID_taken=1, ID_target=0x200 -> ID_branch=1, ID_branch_pc=0x100, misprediction=0, flush never asserted.
- Hit, IF_taken=2'b10, IF_pc=0x100; resolve ID_taken=0 -> misprediction=1; next cycle redirect_valid=1 for one cycle, redirect_pc=0x104, flush=1 for FLUSH_CYCLES cycles, then IDLE.
- Taken with target mismatch: rec_target=0x200, ID_target=0x300 -> misprediction=1, redirect_pc=0x300. An IF branch presented the same cycle is not captured.
- IF_pc=0xFFFFFFFC, predicted taken, actual not taken -> redirect_pc=0x00000000 (wrap).
- Misprediction with FLUSH_CYCLES=3, en=0 for 2 cycles mid-flush -> flush held 5 cycles total. Reset pulse mid-flush -> flush=0 immediately. With BRANCH_STAT_EN defined, the counters read 3/2 after 3 resolves with 2 mispredicts.
